// File: rtl/spram_be_clr.sv
// Single-port RAM with per-byte write enables and a clear sequencer that fills every word with CLEAR_VALUE.
// Define SPRAM_BE_CLR_OUTREG_EN to add an output register (read latency 2 instead of 1).
module spram_be_clr #(
  parameter int                   DATAWIDTH   = 8,
  parameter int                   ADDRWIDTH   = 8,
  parameter int                   NUMWORDS    = 1 << ADDRWIDTH,
  parameter logic [DATAWIDTH-1:0] CLEAR_VALUE = '0,
  parameter int                   BEWIDTH     = (DATAWIDTH + 7) / 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDRWIDTH-1:0] address,
  input  logic [DATAWIDTH-1:0] data,
  input  logic [BEWIDTH-1:0]   byteena,
  input  logic                 wren,
  input  logic                 clear_req,
  output logic                 busy,
  output logic [DATAWIDTH-1:0] q
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(NUMWORDS - 1);
  localparam logic [ADDRWIDTH:0]   DEPTH     = (ADDRWIDTH + 1)'(NUMWORDS);

  state_t                 state_reg, state_next;
  logic [ADDRWIDTH-1:0]   clr_addr_reg, clr_addr_next;
  logic                   clr_we;
  logic                   user_we;
  logic                   in_range;
  logic [ADDRWIDTH-1:0]   mem_addr;
  logic [DATAWIDTH-1:0]   rd_word;
  logic [DATAWIDTH-1:0]   rd_data;
  logic [DATAWIDTH-1:0]   q_pipe;
  logic                   rd_ok_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  // A clear_req during CLEAR restarts the sweep without writing on that edge.
  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    clr_we        = 1'b0;
    unique case (state_reg)
      ST_CLEAR: begin
        if (clear_req) begin
          clr_addr_next = '0;
        end else begin
          clr_we = 1'b1;
          if (clr_addr_reg == LAST_ADDR) begin
            state_next    = ST_READY;
            clr_addr_next = '0;
          end else begin
            clr_addr_next = clr_addr_reg + 1'b1;
          end
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end
      end
      default: begin
        state_next    = ST_CLEAR;
        clr_addr_next = '0;
      end
    endcase
  end

  assign busy     = (state_reg == ST_CLEAR);
  assign in_range = ({1'b0, address} < DEPTH);
  assign user_we  = !busy && wren && in_range;
  assign mem_addr = busy ? clr_addr_reg : address;

  // One write-first RAM per byte lane; the top lane narrows when DATAWIDTH is not a multiple of 8.
  for (genvar gi = 0; gi < BEWIDTH; gi++) begin : g_lane
    localparam int LO = 8 * gi;
    localparam int LW = ((DATAWIDTH - LO) < 8) ? (DATAWIDTH - LO) : 8;

    logic [LW-1:0] lane_mem [NUMWORDS];
    logic [LW-1:0] lane_wdata;
    logic [LW-1:0] lane_q_reg;
    logic          lane_we;

    assign lane_we    = clr_we || (user_we && byteena[gi]);
    assign lane_wdata = busy ? CLEAR_VALUE[LO +: LW] : data[LO +: LW];

    always_ff @(posedge clock) begin
      if (lane_we) begin
        lane_mem[mem_addr] <= lane_wdata;
        lane_q_reg         <= lane_wdata;
      end else begin
        lane_q_reg <= lane_mem[mem_addr];
      end
    end

    assign rd_word[LO +: LW] = lane_q_reg;
  end

  // Reads sampled while clearing or out of range come back as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ok_reg <= 1'b0;
    end else begin
      rd_ok_reg <= !busy && in_range;
    end
  end

  assign rd_data = rd_ok_reg ? rd_word : '0;

`ifdef SPRAM_BE_CLR_OUTREG_EN
  logic [DATAWIDTH-1:0] q_out_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      q_out_reg <= '0;
    end else begin
      q_out_reg <= rd_data;
    end
  end

  assign q_pipe = q_out_reg;
`else
  assign q_pipe = rd_data;
`endif

  assign q = busy ? '0 : q_pipe;

endmodule

// File: tb/tb_spram_be_clr.sv
// Self-checking bench for spram_be_clr: directed vectors plus a per-cycle behavioural model.
// Adapts its read latency to SPRAM_BE_CLR_OUTREG_EN.
module tb_spram_be_clr;

  localparam int NW = 12;
  localparam logic [15:0] CV = 16'hA5A5;
`ifdef SPRAM_BE_CLR_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic [15:0] data;
  logic [1:0]  byteena;
  logic        wren;
  logic        clear_req;
  logic        busy;
  logic [15:0] q;

  int errors = 0;
  int checks = 0;

  spram_be_clr #(
    .DATAWIDTH  (16),
    .ADDRWIDTH  (4),
    .NUMWORDS   (NW),
    .CLEAR_VALUE(CV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data     (data),
    .byteena  (byteena),
    .wren     (wren),
    .clear_req(clear_req),
    .busy     (busy),
    .q        (q)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: busy lasts NW cycles after a reset/clear_req edge, then every word equals CV.
  logic [15:0] mm [NW];
  logic [15:0] pipe [2];
  int          cnt = NW;

  always @(posedge clock) begin
    logic [15:0] rv;
    logic        was_busy;
    logic        exp_busy;
    logic [15:0] exp_q;
    #1;
    if (reset) begin
      cnt     = NW;
      pipe[0] = '0;
      pipe[1] = '0;
    end else begin
      was_busy = (cnt > 0);
      rv = '0;
      if (!was_busy && int'(address) < NW) begin
        rv = mm[address];
        if (wren) begin
          for (int i = 0; i < 2; i++)
            if (byteena[i]) rv[8*i +: 8] = data[8*i +: 8];
        end
        mm[address] = rv;
      end
      if (clear_req) begin
        cnt = NW;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0)
          for (int a = 0; a < NW; a++) mm[a] = CV;
      end
      pipe[1] = pipe[0];
      pipe[0] = rv;
    end
    exp_busy = (cnt > 0);
    exp_q    = exp_busy ? 16'h0000 : pipe[LAT-1];
    check("model_busy", {31'b0, busy}, {31'b0, exp_busy});
    check("model_q", {16'b0, q}, {16'b0, exp_q});
  end

  task automatic wait_clear(input string name, input int exp_len);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    check(name, 32'(n), 32'(exp_len));
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [15:0] exp);
    address = a;
    wren    = 1'b0;
    repeat (LAT) @(negedge clock);
    check(name, {16'b0, q}, {16'b0, exp});
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    address = a;
    data    = d;
    byteena = be;
    wren    = 1'b1;
    @(negedge clock);
    wren = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] e;
    // 1: writes during the initial clear are ignored
    reset = 1'b1; clear_req = 1'b0;
    wren = 1'b1; data = 16'h1234; address = 4'd3; byteena = 2'b11;
    repeat (3) @(negedge clock);
    check("reset_busy", {31'b0, busy}, 32'd1);
    check("reset_q", {16'b0, q}, 32'h0);
    reset = 1'b0;
    wait_clear("clear_len_reset", 12);
    wren = 1'b0;
    for (int a = 0; a < NW; a++) read_check("cleared_word", 4'(a), 16'hA5A5);

    // 2: lane 0 only
    write_word(4'd5, 16'hBEEF, 2'b01);
    read_check("lane0_write", 4'd5, 16'hA5EF);

    // 3: read-during-write returns new data
    address = 4'd7; data = 16'h5A5A; byteena = 2'b11; wren = 1'b1;
    @(negedge clock);
    wren = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    check("rdw_new", {16'b0, q}, 32'h5A5A);

    // 5: out-of-range write dropped, read returns zero
    write_word(4'd13, 16'hFFFF, 2'b11);
    read_check("oob_read", 4'd13, 16'h0000);
    for (int a = 0; a < NW; a++) begin
      e = (a == 5) ? 16'hA5EF : (a == 7) ? 16'h5A5A : 16'hA5A5;
      read_check("after_oob", 4'(a), e);
    end

    // 4: clear_req at clr_addr=6 restarts the sweep with no gap
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    repeat (6) @(negedge clock);
    check("mid_clear_busy", {31'b0, busy}, 32'd1);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    wait_clear("clear_len_restart", 12);
    read_check("reclear_5", 4'd5, 16'hA5A5);
    read_check("reclear_7", 4'd7, 16'hA5A5);

    // 6: reset together with clear_req mid-clear, then repeat the basic writes
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1; clear_req = 1'b1;
    @(negedge clock);
    reset = 1'b0; clear_req = 1'b0;
    check("reset_mid_q", {16'b0, q}, 32'h0);
    wait_clear("clear_len_reset2", 12);
    read_check("post_reset_3", 4'd3, 16'hA5A5);
    write_word(4'd5, 16'hBEEF, 2'b01);
    read_check("lane0_write2", 4'd5, 16'hA5EF);
    write_word(4'd2, 16'h1234, 2'b10);
    read_check("lane1_write", 4'd2, 16'h12A5);
    address = 4'd7; data = 16'h5A5A; byteena = 2'b11; wren = 1'b1;
    @(negedge clock);
    wren = 1'b0;
    repeat (LAT - 1) @(negedge clock);
    check("rdw_new2", {16'b0, q}, 32'h5A5A);
    write_word(4'd9, 16'h1111, 2'b00);
    read_check("be_zero_noop", 4'd9, 16'hA5A5);
    read_check("last_word", 4'd11, 16'hA5A5);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
